lif_neuron_scheduler: RTL and testbench

Time-multiplexes one leaky-integrate-and-fire update datapath across N_NEURONS virtual neurons whose membrane potentials live in a local register file. It accepts synaptic events over a valid/ready handshake and runs a leak/threshold scan on each timestep tick. Resulting spikes are queued in a small FIFO for the output pins. It sits between the ui_in synapse path and the top-level uo_out/uio_out spike and membrane outputs.

---
 rtl/lif_pkg.sv | 25 ++
 rtl/spike_fifo.sv | 52 +++++
 rtl/lif_neuron_scheduler.sv | 147 ++++++++++++++
 tb/tb_lif_neuron_scheduler.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types and arithmetic helpers for the LIF neuron scheduler.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package lif_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [7:0] V_MAX = 8'hFF;

  // Unsigned 8-bit add that clamps at V_MAX instead of wrapping.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? V_MAX : sum[7:0];
  endfunction

  // Leaky decay: subtract v >> shift; shift 0 means the membrane does not leak.
  function automatic logic [7:0] leak(input logic [7:0] v, input logic [2:0] shift);
    return (shift == 3'd0) ? v : (v - (v >> shift));
  endfunction

endpackage

// File: rtl/spike_fifo.sv
// First-word-fall-through FIFO for spike events with full/empty status.
// Latency: a push is visible at the head on the cycle after the write edge.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module spike_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // Status flags and the effective push/pop decisions; a pop frees a slot in the same cycle.
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_pop   = pop_rdy && !empty;
    do_push  = push_vld && (!full || do_pop);
    head_vld = !empty;
    head_dat = mem[rd_ptr[AW-1:0]];
  end

  // Pointer and storage update; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexed leaky-integrate-and-fire engine over N_NEURONS virtual neurons.
// Latency: tick -> neuron k spike at head after k+2 cycles; v_mem one cycle after v_sel.
// Backpressure: syn_ready low during a scan; spikes are dropped and counted when the FIFO is full.
module lif_neuron_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS  = 4,
  parameter int IDX_W      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int REFRAC     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             syn_valid,
  output logic             syn_ready,
  input  logic [IDX_W-1:0] syn_idx,
  input  logic [7:0]       syn_weight,
  input  logic [7:0]       cfg_threshold,
  input  logic [2:0]       cfg_leak_shift,
  output logic             spike_valid,
  input  logic             spike_ready,
  output logic [IDX_W-1:0] spike_idx,
  input  logic [IDX_W-1:0] v_sel,
  output logic [7:0]       v_mem,
  output logic             busy,
  output logic [7:0]       drop_cnt
);

  localparam logic [3:0]       REFRAC_V = 4'(REFRAC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] ptr;
  logic             pending_tick;
  logic [7:0]       thr_q;
  logic [2:0]       shift_q;
  logic [7:0]       v    [N_NEURONS];
  logic [3:0]       refr [N_NEURONS];

  logic             syn_fire;
  logic             scan_start;
  logic             scan_last;
  logic [7:0]       v_leaked;
  logic             in_refr;
  logic             fire;
  logic             spike_pop;
  logic             fifo_full;

  // Handshake, scan control and the per-slot leak/threshold decision.
  always_comb begin
    syn_ready  = (state == ST_IDLE);
    busy       = (state == ST_SCAN);
    syn_fire   = syn_valid && syn_ready;
    scan_start = (state == ST_IDLE) && (tick || pending_tick);
    scan_last  = (ptr == LAST_IDX);
    in_refr    = (refr[ptr] != 4'd0);
    v_leaked   = leak(v[ptr], shift_q);
    fire       = busy && !in_refr && (thr_q != 8'd0) && (v_leaked >= thr_q);
    spike_pop  = spike_valid && spike_ready;
  end

  // Next-state logic: a tick (live or remembered) starts a scan, the last slot ends it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (scan_start) state_nxt = ST_SCAN;
      ST_SCAN: if (scan_last)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Scan pointer, one-deep tick memory, and config latched when a scan begins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr          <= '0;
      pending_tick <= 1'b0;
      thr_q        <= 8'd0;
      shift_q      <= 3'd0;
    end else begin
      if (busy) ptr <= scan_last ? '0 : ptr + 1'b1;
      if (scan_start) begin
        pending_tick <= 1'b0;
        thr_q        <= cfg_threshold;
        shift_q      <= cfg_leak_shift;
      end else if (busy && tick) begin
        pending_tick <= 1'b1;
      end
    end
  end

  // Membrane and refractory register file: synaptic integrate in IDLE, leak/fire in SCAN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v[i]    <= 8'd0;
        refr[i] <= 4'd0;
      end
    end else if (syn_fire) begin
      if (refr[syn_idx] == 4'd0) v[syn_idx] <= sat_add8(v[syn_idx], syn_weight);
    end else if (busy) begin
      if (in_refr) begin
        refr[ptr] <= refr[ptr] - 4'd1;
        v[ptr]    <= 8'd0;
      end else if (fire) begin
        refr[ptr] <= REFRAC_V;
        v[ptr]    <= 8'd0;
      end else begin
        v[ptr]    <= v_leaked;
      end
    end
  end

  // Registered membrane readback; shows the value held before this edge's write.
  always_ff @(posedge clk) begin
    if (!rst_n) v_mem <= 8'd0;
    else        v_mem <= v[v_sel];
  end

  // Count spikes lost when the FIFO is full and nothing leaves it this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) drop_cnt <= 8'd0;
    else if (fire && fifo_full && !spike_pop && (drop_cnt != V_MAX)) drop_cnt <= drop_cnt + 8'd1;
  end

  spike_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IDX_W)
  ) u_spike_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (fire),
    .push_dat (ptr),
    .pop_rdy  (spike_ready),
    .head_vld (spike_valid),
    .head_dat (spike_idx),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
module tb_lif_neuron_scheduler;

  localparam int N      = 4;
  localparam int IW     = 2;
  localparam int DEPTH  = 4;
  localparam int REFRAC = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tick;
  logic          syn_valid;
  logic          syn_ready;
  logic [IW-1:0] syn_idx;
  logic [7:0]    syn_weight;
  logic [7:0]    cfg_threshold;
  logic [2:0]    cfg_leak_shift;
  logic          spike_valid;
  logic          spike_ready;
  logic [IW-1:0] spike_idx;
  logic [IW-1:0] v_sel;
  logic [7:0]    v_mem;
  logic          busy;
  logic [7:0]    drop_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural reference state
  int m_v    [N];
  int m_refr [N];
  int m_q    [$];
  int m_drop;

  always #5 clk = ~clk;

  lif_neuron_scheduler #(
    .N_NEURONS (N), .IDX_W (IW), .FIFO_DEPTH (DEPTH), .REFRAC (REFRAC)
  ) dut (
    .clk (clk), .rst_n (rst_n), .tick (tick),
    .syn_valid (syn_valid), .syn_ready (syn_ready), .syn_idx (syn_idx), .syn_weight (syn_weight),
    .cfg_threshold (cfg_threshold), .cfg_leak_shift (cfg_leak_shift),
    .spike_valid (spike_valid), .spike_ready (spike_ready), .spike_idx (spike_idx),
    .v_sel (v_sel), .v_mem (v_mem), .busy (busy), .drop_cnt (drop_cnt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i]    = 0;
      m_refr[i] = 0;
    end
    m_q.delete();
    m_drop = 0;
  endtask

  task automatic model_event(input int idx, input int w);
    if (m_refr[idx] == 0) m_v[idx] = (m_v[idx] + w > 255) ? 255 : m_v[idx] + w;
  endtask

  task automatic model_scan(input int thr, input int sh);
    int vl;
    for (int i = 0; i < N; i++) begin
      if (m_refr[i] > 0) begin
        m_refr[i] = m_refr[i] - 1;
        m_v[i]    = 0;
      end else begin
        vl = (sh == 0) ? m_v[i] : m_v[i] - (m_v[i] >> sh);
        if (thr != 0 && vl >= thr) begin
          m_v[i]    = 0;
          m_refr[i] = REFRAC;
          if (m_q.size() < DEPTH) m_q.push_back(i);
          else if (m_drop < 255) m_drop = m_drop + 1;
        end else begin
          m_v[i] = vl;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic send_syn(input int idx, input int w);
    int n = 0;
    while (!syn_ready && n < 50) begin
      cyc();
      n++;
    end
    if (!syn_ready) begin
      checks++; errors++;
      $display("FAIL send_syn_timeout: syn_ready=%0b required 1", syn_ready);
    end
    syn_valid  = 1'b1;
    syn_idx    = IW'(idx);
    syn_weight = 8'(w);
    cyc();
    syn_valid  = 1'b0;
    model_event(idx, w);
  endtask

  // Tick, then scramble the config to confirm it was latched at scan start.
  task automatic do_tick(input int thr, input int sh);
    int n = 0;
    cfg_threshold  = 8'(thr);
    cfg_leak_shift = 3'(sh);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cfg_threshold  = 8'($urandom);
    cfg_leak_shift = 3'($urandom);
    while (busy && n < 50) begin
      cyc();
      n++;
    end
    checks++;
    if (n !== N) begin
      errors++;
      $display("FAIL scan_length: busy cycles=%0d required %0d", n, N);
    end
    model_scan(thr, sh);
  endtask

  task automatic test_membranes(input string tag);
    for (int i = 0; i < N; i++) begin
      v_sel = IW'(i);
      cyc();
      checks++;
      if (v_mem !== 8'(m_v[i])) begin
        errors++;
        $display("FAIL %s_v%0d: v_mem=%0d required %0d", tag, i, v_mem, m_v[i]);
      end
    end
  endtask

  task automatic test_drain(input string tag);
    int exp;
    checks++;
    if (drop_cnt !== 8'(m_drop)) begin
      errors++;
      $display("FAIL %s_drop: drop_cnt=%0d required %0d", tag, drop_cnt, m_drop);
    end
    spike_ready = 1'b1;
    while (m_q.size() > 0) begin
      exp = m_q.pop_front();
      checks++;
      if (spike_valid !== 1'b1 || spike_idx !== IW'(exp)) begin
        errors++;
        $display("FAIL %s_pop: valid=%0b idx=%0d required valid=1 idx=%0d", tag, spike_valid, spike_idx, exp);
      end
      cyc();
    end
    spike_ready = 1'b0;
    checks++;
    if (spike_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_empty: spike_valid=%0b required 0", tag, spike_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (syn_ready !== 1'b1 || spike_valid !== 1'b0 || spike_idx !== '0 ||
        v_mem !== 8'd0 || busy !== 1'b0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%0b sv=%0b si=%0d vm=%0d busy=%0b drop=%0d required 1 0 0 0 0 0",
               syn_ready, spike_valid, spike_idx, v_mem, busy, drop_cnt);
    end
  endtask

  task automatic test_reset_midscan();
    do_reset();
    send_syn(0, 200);
    send_syn(1, 200);
    cfg_threshold  = 8'd50;
    cfg_leak_shift = 3'd0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc();
    cyc();
    checks++;
    if (spike_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midscan_pre: spike_valid=%0b busy=%0b required 1 1", spike_valid, busy);
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    model_reset();
    checks++;
    if (busy !== 1'b0 || spike_valid !== 1'b0 || syn_ready !== 1'b1 || v_mem !== 8'd0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midscan_reset: busy=%0b sv=%0b rdy=%0b vm=%0d drop=%0d required 0 0 1 0 0",
               busy, spike_valid, syn_ready, v_mem, drop_cnt);
    end
    test_membranes("midscan");
  endtask

  task automatic test_integrate_fire();
    int n = 0;
    do_reset();
    send_syn(1, 60);
    send_syn(1, 60);
    v_sel = 2'd1;
    cyc();
    checks++;
    if (v_mem !== 8'd120) begin
      errors++;
      $display("FAIL if_integrate: v_mem=%0d required 120", v_mem);
    end
    cfg_threshold  = 8'd100;
    cfg_leak_shift = 3'd0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    checks++;
    if (busy !== 1'b1 || spike_valid !== 1'b0) begin
      errors++;
      $display("FAIL if_tick1: busy=%0b spike_valid=%0b required 1 0", busy, spike_valid);
    end
    cyc();
    checks++;
    if (spike_valid !== 1'b0) begin
      errors++;
      $display("FAIL if_tick2: spike_valid=%0b required 0", spike_valid);
    end
    cyc();
    checks++;
    if (spike_valid !== 1'b1 || spike_idx !== 2'd1) begin
      errors++;
      $display("FAIL if_tick3: valid=%0b idx=%0d required 1 1", spike_valid, spike_idx);
    end
    while (busy && n < 50) begin
      cyc();
      n++;
    end
    model_scan(100, 0);
    send_syn(1, 200);
    v_sel = 2'd1;
    cyc();
    checks++;
    if (v_mem !== 8'd0) begin
      errors++;
      $display("FAIL if_refractory_discard: v_mem=%0d required 0", v_mem);
    end
    do_tick(100, 0);
    test_membranes("if");
    test_drain("if");
  endtask

  task automatic test_leak_sat();
    do_reset();
    send_syn(0, 200);
    send_syn(0, 200);
    v_sel = 2'd0;
    cyc();
    checks++;
    if (v_mem !== 8'd255) begin
      errors++;
      $display("FAIL leak_saturate: v_mem=%0d required 255", v_mem);
    end
    do_tick(0, 1);
    v_sel = 2'd0;
    cyc();
    checks++;
    if (v_mem !== 8'd128) begin
      errors++;
      $display("FAIL leak_first: v_mem=%0d required 128", v_mem);
    end
    do_tick(0, 1);
    v_sel = 2'd0;
    cyc();
    checks++;
    if (v_mem !== 8'd64) begin
      errors++;
      $display("FAIL leak_second: v_mem=%0d required 64", v_mem);
    end
    test_membranes("leak");
    test_drain("leak");
  endtask

  task automatic test_handshake();
    int n = 0;
    int idle_busy = 0;
    do_reset();
    send_syn(0, 30);
    cfg_threshold  = 8'd200;
    cfg_leak_shift = 3'd0;
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    syn_valid  = 1'b1;
    syn_idx    = 2'd2;
    syn_weight = 8'd50;
    checks++;
    if (syn_ready !== 1'b0) begin
      errors++;
      $display("FAIL hs_ready_scan: syn_ready=%0b required 0", syn_ready);
    end
    cyc();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    while (!syn_ready && n < 50) begin
      cyc();
      n++;
    end
    cyc();
    syn_valid = 1'b0;
    model_scan(200, 0);
    model_event(2, 50);
    n = 0;
    while (busy && n < 50) begin
      cyc();
      n++;
    end
    checks++;
    if (n !== N) begin
      errors++;
      $display("FAIL hs_pending_scan: busy cycles=%0d required %0d", n, N);
    end
    model_scan(200, 0);
    for (int i = 0; i < 6; i++) begin
      if (busy) idle_busy++;
      cyc();
    end
    checks++;
    if (idle_busy !== 0) begin
      errors++;
      $display("FAIL hs_single_extra: extra busy cycles=%0d required 0", idle_busy);
    end
    test_membranes("hs");
  endtask

  task automatic test_fifo_overflow();
    do_reset();
    for (int i = 0; i < N; i++) send_syn(i, 10);
    do_tick(1, 0);
    for (int t = 0; t < REFRAC; t++) begin
      for (int i = 0; i < N; i++) send_syn(i, 10);
      do_tick(1, 0);
    end
    for (int i = 0; i < N; i++) send_syn(i, 10);
    do_tick(1, 0);
    checks++;
    if (drop_cnt !== 8'd4 || spike_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: drop_cnt=%0d valid=%0b required 4 1", drop_cnt, spike_valid);
    end
    test_drain("ovf");
  endtask

  task automatic test_simultaneous();
    int n = 0;
    do_reset();
    send_syn(3, 60);
    cfg_threshold  = 8'd100;
    cfg_leak_shift = 3'd0;
    syn_valid  = 1'b1;
    syn_idx    = 2'd3;
    syn_weight = 8'd60;
    tick       = 1'b1;
    checks++;
    if (syn_ready !== 1'b1) begin
      errors++;
      $display("FAIL sim_ready: syn_ready=%0b required 1", syn_ready);
    end
    cyc();
    syn_valid = 1'b0;
    tick      = 1'b0;
    model_event(3, 60);
    while (busy && n < 50) begin
      cyc();
      n++;
    end
    model_scan(100, 0);
    checks++;
    if (spike_valid !== 1'b1 || spike_idx !== 2'd3) begin
      errors++;
      $display("FAIL sim_fire: valid=%0b idx=%0d required 1 3", spike_valid, spike_idx);
    end
    test_drain("sim");
  endtask

  task automatic test_random();
    int op;
    do_reset();
    for (int k = 0; k < 120; k++) begin
      op = $urandom_range(0, 9);
      if (op <= 5)      send_syn($urandom_range(0, N - 1), $urandom_range(0, 255));
      else if (op <= 7) do_tick($urandom_range(0, 255), $urandom_range(0, 7));
      else if (op == 8) test_drain("rnd");
      else              test_membranes("rnd");
    end
    test_membranes("rnd_end");
    test_drain("rnd_end");
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; syn_valid = 1'b0; syn_idx = '0; syn_weight = 8'd0;
    cfg_threshold = 8'd0; cfg_leak_shift = 3'd0; spike_ready = 1'b0; v_sel = '0;
    model_reset();
    test_reset();
    test_integrate_fire();
    test_leak_sat();
    test_handshake();
    test_fifo_overflow();
    test_simultaneous();
    test_reset_midscan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
